// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg
// Shared types and constants for the multicycle controller slice:
//   state_t    - FSM state encoding (also driven out on the debug state port)
//   opclass_t  - decoded instruction class produced by opcode_class
//   OP_*       - RV32 major opcodes the controller understands
//   ALU_*      - alu_op encodings
//   WB_SEL_*   - mem_to_reg write-back source encodings
//   ERR_*      - sticky error codes
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_ALU = 4'd7,
    WB_MEM = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    HALT   = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_I       = 3'd1,
    CLS_LOAD    = 3'd2,
    CLS_STORE   = 3'd3,
    CLS_BRANCH  = 3'd4,
    CLS_JAL     = 3'd5,
    CLS_ILLEGAL = 3'd6
  } opclass_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_BRANCH = 2'b01;
  localparam logic [1:0] ALU_RTYPE  = 2'b10;
  localparam logic [1:0] ALU_ITYPE  = 2'b11;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  // Wide enough for the largest supported WAIT_MAX (255).
  localparam int WAIT_CNT_W = 8;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if
// Bundles the controller's handshake and control signals.
//   master modport - the controller: takes opcode/mem_ready/ctrl_src/flush,
//                    drives all enables, selects, err and debug state
//   slave modport  - the datapath/memory side, the mirror image
interface multicycle_control_if #(
  parameter int ALUOP_W = 2
);

  logic [6:0]         opcode;
  logic               mem_ready;
  logic               ctrl_src;
  logic               flush;
  logic               pc_write;
  logic               ir_write;
  logic               mem_read;
  logic               mem_write;
  logic               reg_write;
  logic [1:0]         mem_to_reg;
  logic               alu_src;
  logic [ALUOP_W-1:0] alu_op;
  logic               branch;
  logic [1:0]         err;
  logic [3:0]         state;

  modport master (
    input  opcode, mem_ready, ctrl_src, flush,
    output pc_write, ir_write, mem_read, mem_write, reg_write,
           mem_to_reg, alu_src, alu_op, branch, err, state
  );

  modport slave (
    output opcode, mem_ready, ctrl_src, flush,
    input  pc_write, ir_write, mem_read, mem_write, reg_write,
           mem_to_reg, alu_src, alu_op, branch, err, state
  );

endinterface

// File: rtl/multicycle_control_opcode_class.sv
// opcode_class
// Purely combinational opcode classifier used by the DECODE state.
//   i_opcode - instruction[6:0]
//   o_class  - instruction class; anything unrecognised is CLS_ILLEGAL
// EN_JAL = 0 makes JAL decode as illegal.
module opcode_class
  import multicycle_control_pkg::*;
#(
  parameter bit EN_JAL = 1'b1
) (
  input  logic [6:0] i_opcode,
  output opclass_t   o_class
);

  // Map the major opcode onto the small set of classes the FSM branches on.
  always_comb begin
    o_class = CLS_ILLEGAL;
    case (i_opcode)
      OP_R:      o_class = CLS_R;
      OP_I:      o_class = CLS_I;
      OP_LOAD:   o_class = CLS_LOAD;
      OP_STORE:  o_class = CLS_STORE;
      OP_BRANCH: o_class = CLS_BRANCH;
      OP_JAL:    o_class = EN_JAL ? CLS_JAL : CLS_ILLEGAL;
      default:   o_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control
// Multicycle RISC-V style control FSM.
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - multicycle_control_if.master: opcode, mem_ready, ctrl_src, flush in;
//          pc_write, ir_write, mem_read, mem_write, reg_write, mem_to_reg,
//          alu_src, alu_op, branch, err (sticky), state (debug) out
// Outputs are combinational from the registered state, gated by mem_ready,
// ctrl_src, flush and rst, so there is no added latency.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter bit EN_JAL   = 1'b1,
  parameter int ALUOP_W  = 2
) (
  input logic clk,
  input logic rst,
  multicycle_control_if.master bus
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(WAIT_MAX);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE    = WAIT_CNT_W'(1);

  state_t                r_state;
  state_t                w_nextState;
  logic [WAIT_CNT_W-1:0] r_waitCount;
  logic [WAIT_CNT_W-1:0] w_nextWaitCount;
  logic [1:0]            r_err;
  logic [1:0]            w_nextErr;
  opclass_t              w_class;
  logic                  w_waitExpired;
  logic                  w_flushActive;

  logic                  w_pcWrite;
  logic                  w_irWrite;
  logic                  w_memRead;
  logic                  w_memWrite;
  logic                  w_regWrite;
  logic [1:0]            w_memToReg;
  logic                  w_aluSrc;
  logic [1:0]            w_aluOp;
  logic                  w_branch;

  opcode_class #(
    .EN_JAL (EN_JAL)
  ) u_opcodeClass (
    .i_opcode (bus.opcode),
    .o_class  (w_class)
  );

  // This cycle's wait would be the WAIT_MAX-th one without mem_ready.
  assign w_waitExpired = (r_waitCount + CNT_ONE) >= WAIT_LIMIT;
  // HALT is only left through reset, so flush is meaningless there.
  assign w_flushActive = bus.flush && (r_state != HALT);

  // State, wait counter and sticky error register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= FETCH;
      r_waitCount <= '0;
      r_err       <= ERR_NONE;
    end else begin
      r_state     <= w_nextState;
      r_waitCount <= w_nextWaitCount;
      r_err       <= w_nextErr;
    end
  end

  // Next-state logic. The counter defaults to zero so that every entry into
  // a wait state starts counting afresh; it only advances while a wait state
  // is stalled on mem_ready, and freezes along with the state under ctrl_src.
  always_comb begin
    w_nextState     = r_state;
    w_nextWaitCount = '0;
    w_nextErr       = r_err;
    if (w_flushActive) begin
      w_nextState = FETCH;
    end else if (bus.ctrl_src) begin
      w_nextWaitCount = r_waitCount;
    end else begin
      case (r_state)
        FETCH, MEM_RD, MEM_WR: begin
          if (bus.mem_ready) begin
            case (r_state)
              FETCH:   w_nextState = DECODE;
              MEM_RD:  w_nextState = WB_MEM;
              default: w_nextState = FETCH;
            endcase
          end else if (w_waitExpired) begin
            w_nextState = HALT;
            w_nextErr   = ERR_TIMEOUT;
          end else begin
            w_nextWaitCount = r_waitCount + CNT_ONE;
          end
        end
        DECODE: begin
          case (w_class)
            CLS_R:                w_nextState = EXEC_R;
            CLS_I:                w_nextState = EXEC_I;
            CLS_LOAD, CLS_STORE:  w_nextState = ADDR;
            CLS_BRANCH:           w_nextState = BRANCH;
            CLS_JAL:              w_nextState = JUMP;
            default: begin
              w_nextState = HALT;
              w_nextErr   = ERR_ILLEGAL;
            end
          endcase
        end
        EXEC_R, EXEC_I:  w_nextState = WB_ALU;
        ADDR:            w_nextState = (bus.opcode == OP_LOAD) ? MEM_RD : MEM_WR;
        WB_ALU, WB_MEM:  w_nextState = FETCH;
        BRANCH, JUMP:    w_nextState = FETCH;
        HALT:            w_nextState = HALT;
        default:         w_nextState = FETCH;
      endcase
    end
  end

  // Output decode. Each state sets only what it uses; flush and ctrl_src then
  // strip the write enables and memory requests, and reset silences all of it.
  always_comb begin
    w_pcWrite  = 1'b0;
    w_irWrite  = 1'b0;
    w_memRead  = 1'b0;
    w_memWrite = 1'b0;
    w_regWrite = 1'b0;
    w_memToReg = WB_SEL_ALU;
    w_aluSrc   = 1'b0;
    w_aluOp    = ALU_ADD;
    w_branch   = 1'b0;
    case (r_state)
      FETCH: begin
        w_memRead = 1'b1;
        w_pcWrite = bus.mem_ready;
        w_irWrite = bus.mem_ready;
      end
      EXEC_R: w_aluOp = ALU_RTYPE;
      EXEC_I: begin
        w_aluSrc = 1'b1;
        w_aluOp  = ALU_ITYPE;
      end
      ADDR: begin
        w_aluSrc = 1'b1;
        w_aluOp  = ALU_ADD;
      end
      MEM_RD: w_memRead  = 1'b1;
      MEM_WR: w_memWrite = 1'b1;
      WB_ALU: begin
        w_regWrite = 1'b1;
        w_memToReg = WB_SEL_ALU;
      end
      WB_MEM: begin
        w_regWrite = 1'b1;
        w_memToReg = WB_SEL_MEM;
      end
      BRANCH: begin
        w_branch = 1'b1;
        w_aluOp  = ALU_BRANCH;
      end
      JUMP: begin
        w_pcWrite  = 1'b1;
        w_regWrite = 1'b1;
        w_memToReg = WB_SEL_PC4;
      end
      default: ;
    endcase
    if (w_flushActive || bus.ctrl_src) begin
      w_pcWrite  = 1'b0;
      w_irWrite  = 1'b0;
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
      w_regWrite = 1'b0;
    end
    if (rst) begin
      w_pcWrite  = 1'b0;
      w_irWrite  = 1'b0;
      w_memRead  = 1'b0;
      w_memWrite = 1'b0;
      w_regWrite = 1'b0;
      w_memToReg = WB_SEL_ALU;
      w_aluSrc   = 1'b0;
      w_aluOp    = ALU_ADD;
      w_branch   = 1'b0;
    end
  end

  assign bus.pc_write   = w_pcWrite;
  assign bus.ir_write   = w_irWrite;
  assign bus.mem_read   = w_memRead;
  assign bus.mem_write  = w_memWrite;
  assign bus.reg_write  = w_regWrite;
  assign bus.mem_to_reg = w_memToReg;
  assign bus.alu_src    = w_aluSrc;
  assign bus.alu_op     = ALUOP_W'(w_aluOp);
  assign bus.branch     = w_branch;
  assign bus.err        = r_err;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control
// Scoreboard bench: each test pushes the expected output vector for a cycle
// as it drives that cycle's inputs, then pops and compares at mid-cycle.
// dutA uses defaults (WAIT_MAX=15, EN_JAL=1); dutB uses WAIT_MAX=4, EN_JAL=0.
`timescale 1ns/1ps
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mr, mw, rw;
    logic [1:0] m2r;
    logic       asrc;
    logic [1:0] aop;
    logic       br;
    logic [1:0] er;
  } exp_t;

  typedef struct packed {
    logic rdy, cs, fl;
    exp_t e;
  } stim_t;

  logic clk;
  logic rst;
  exp_t expQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  multicycle_control_if #(.ALUOP_W(2)) busA ();
  multicycle_control_if #(.ALUOP_W(2)) busB ();

  multicycle_control #(.WAIT_MAX(15), .EN_JAL(1'b1), .ALUOP_W(2)) dutA (
    .clk (clk), .rst (rst), .bus (busA)
  );
  multicycle_control #(.WAIT_MAX(4), .EN_JAL(1'b0), .ALUOP_W(2)) dutB (
    .clk (clk), .rst (rst), .bus (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  function automatic exp_t ev(state_t st, logic pcw, logic irw, logic mr, logic mw,
                              logic rw, logic [1:0] m2r, logic asrc, logic [1:0] aop,
                              logic br, logic [1:0] er);
    return {st, pcw, irw, mr, mw, rw, m2r, asrc, aop, br, er};
  endfunction

  function automatic exp_t eFetch(logic rdy, logic [1:0] er);
    return ev(FETCH, rdy, rdy, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, er);
  endfunction

  function automatic exp_t eZero(state_t st, logic [1:0] er);
    return ev(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, er);
  endfunction

  function automatic stim_t mkStim(logic rdy, logic cs, logic fl, exp_t e);
    return {rdy, cs, fl, e};
  endfunction

  function automatic exp_t observe(bit useB);
    if (useB)
      return {busB.state, busB.pc_write, busB.ir_write, busB.mem_read, busB.mem_write,
              busB.reg_write, busB.mem_to_reg, busB.alu_src, busB.alu_op, busB.branch,
              busB.err};
    return {busA.state, busA.pc_write, busA.ir_write, busA.mem_read, busA.mem_write,
            busA.reg_write, busA.mem_to_reg, busA.alu_src, busA.alu_op, busA.branch,
            busA.err};
  endfunction

  // Drives one cycle of inputs, records the expectation, moves to mid-cycle.
  task automatic applyStimulus(bit useB, stim_t s);
    if (useB) begin
      busB.mem_ready = s.rdy; busB.ctrl_src = s.cs; busB.flush = s.fl;
    end else begin
      busA.mem_ready = s.rdy; busA.ctrl_src = s.cs; busA.flush = s.fl;
    end
    expQ.push_back(s.e);
    #4;
  endtask

  task automatic doReset();
    rst = 1'b1;
    busA.mem_ready = 1'b0; busA.ctrl_src = 1'b0; busA.flush = 1'b0;
    busB.mem_ready = 1'b0; busB.ctrl_src = 1'b0; busB.flush = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t got;
    rst = 1'b1;
    busA.mem_ready = 1'b1; busB.mem_ready = 1'b1;
    #1;
    got = observe(0); nChecks++;
    if (got !== eZero(FETCH, 2'd0)) begin
      nFails++; $display("[TB] FAIL reset_A: got %h expected %h", got, eZero(FETCH, 2'd0));
    end
    got = observe(1); nChecks++;
    if (got !== eZero(FETCH, 2'd0)) begin
      nFails++; $display("[TB] FAIL reset_B: got %h expected %h", got, eZero(FETCH, 2'd0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, mkStim(1'b0, 1'b0, 1'b0, eFetch(1'b0, 2'd0)));
    got = observe(0); nChecks++;
    if (got !== expQ.pop_front()) begin
      nFails++; $display("[TB] FAIL first_request: got %h expected %h", got, eFetch(1'b0, 2'd0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    stim_t seq[$]; exp_t got, want;
    doReset(); busA.opcode = OP_R;
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(EXEC_R, 0, 0, 0, 0, 0, 2'd0, 0, 2'b10, 0, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(WB_ALU, 0, 0, 0, 0, 1, 2'd0, 0, 2'b00, 0, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    foreach (seq[k]) begin
      applyStimulus(0, seq[k]);
      got = observe(0); want = expQ.pop_front(); nChecks++;
      if (got !== want) begin nFails++; $display("[TB] FAIL add[%0d]: got %h expected %h", k, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_itype_flush();
    stim_t seq[$]; exp_t got, want;
    doReset(); busA.opcode = OP_I;
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(EXEC_I, 0, 0, 0, 0, 0, 2'd0, 1, 2'b11, 0, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(WB_ALU, 0, 0, 0, 0, 1, 2'd0, 0, 2'b00, 0, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    seq.push_back(mkStim(1, 0, 1, ev(EXEC_I, 0, 0, 0, 0, 0, 2'd0, 1, 2'b11, 0, 2'd0)));
    seq.push_back(mkStim(1, 0, 1, eZero(FETCH, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    foreach (seq[k]) begin
      applyStimulus(0, seq[k]);
      got = observe(0); want = expQ.pop_front(); nChecks++;
      if (got !== want) begin nFails++; $display("[TB] FAIL itype_flush[%0d]: got %h expected %h", k, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_stall();
    stim_t seq[$]; exp_t got, want;
    doReset(); busA.opcode = OP_LOAD;
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(ADDR, 0, 0, 0, 0, 0, 2'd0, 1, 2'b00, 0, 2'd0)));
    for (int i = 0; i < 4; i++)
      seq.push_back(mkStim(i == 3, 0, 0, ev(MEM_RD, 0, 0, 1, 0, 0, 2'd0, 0, 2'b00, 0, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(WB_MEM, 0, 0, 0, 0, 1, 2'd1, 0, 2'b00, 0, 2'd0)));
    seq.push_back(mkStim(0, 0, 0, eFetch(1'b0, 2'd0)));
    foreach (seq[k]) begin
      applyStimulus(0, seq[k]);
      got = observe(0); want = expQ.pop_front(); nChecks++;
      if (got !== want) begin nFails++; $display("[TB] FAIL load[%0d]: got %h expected %h", k, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_store_freeze();
    stim_t seq[$]; exp_t got, want;
    doReset(); busA.opcode = OP_STORE;
    seq.push_back(mkStim(1, 1, 0, eZero(FETCH, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(ADDR, 0, 0, 0, 0, 0, 2'd0, 1, 2'b00, 0, 2'd0)));
    seq.push_back(mkStim(0, 1, 0, eZero(MEM_WR, 2'd0)));
    seq.push_back(mkStim(0, 1, 0, eZero(MEM_WR, 2'd0)));
    seq.push_back(mkStim(0, 0, 0, ev(MEM_WR, 0, 0, 0, 1, 0, 2'd0, 0, 2'b00, 0, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(MEM_WR, 0, 0, 0, 1, 0, 2'd0, 0, 2'b00, 0, 2'd0)));
    seq.push_back(mkStim(0, 0, 0, eFetch(1'b0, 2'd0)));
    foreach (seq[k]) begin
      applyStimulus(0, seq[k]);
      got = observe(0); want = expQ.pop_front(); nChecks++;
      if (got !== want) begin nFails++; $display("[TB] FAIL store[%0d]: got %h expected %h", k, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jal();
    stim_t seq[$]; exp_t got, want;
    doReset(); busA.opcode = OP_BRANCH;
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(BRANCH, 0, 0, 0, 0, 0, 2'd0, 0, 2'b01, 1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(JUMP, 1, 0, 0, 0, 1, 2'd2, 0, 2'b00, 0, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    foreach (seq[k]) begin
      if (k == 4) busA.opcode = OP_JAL;
      applyStimulus(0, seq[k]);
      got = observe(0); want = expQ.pop_front(); nChecks++;
      if (got !== want) begin nFails++; $display("[TB] FAIL branch_jal[%0d]: got %h expected %h", k, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    stim_t seq[$]; exp_t got, want;
    doReset(); busA.opcode = 7'b1111111;
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    seq.push_back(mkStim(1, 0, 1, eZero(HALT, 2'd1)));
    seq.push_back(mkStim(1, 0, 1, eZero(HALT, 2'd1)));
    seq.push_back(mkStim(1, 0, 0, eZero(HALT, 2'd1)));
    foreach (seq[k]) begin
      applyStimulus(0, seq[k]);
      got = observe(0); want = expQ.pop_front(); nChecks++;
      if (got !== want) begin nFails++; $display("[TB] FAIL illegal[%0d]: got %h expected %h", k, got, want); end
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    got = observe(0); nChecks++;
    if (got !== eZero(FETCH, 2'd0)) begin
      nFails++; $display("[TB] FAIL illegal_reset: got %h expected %h", got, eZero(FETCH, 2'd0));
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    stim_t seq[$]; exp_t got, want;
    doReset(); busA.opcode = OP_R;
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, ev(EXEC_R, 0, 0, 0, 0, 0, 2'd0, 0, 2'b10, 0, 2'd0)));
    foreach (seq[k]) begin
      applyStimulus(0, seq[k]);
      got = observe(0); want = expQ.pop_front(); nChecks++;
      if (got !== want) begin nFails++; $display("[TB] FAIL mid_reset[%0d]: got %h expected %h", k, got, want); end
      @(posedge clk); #1;
    end
    rst = 1'b1; #1;
    got = observe(0); nChecks++;
    if (got !== eZero(FETCH, 2'd0)) begin
      nFails++; $display("[TB] FAIL mid_reset_async: got %h expected %h", got, eZero(FETCH, 2'd0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(0, mkStim(1'b1, 1'b0, 1'b0, eFetch(1'b1, 2'd0)));
    got = observe(0); want = expQ.pop_front(); nChecks++;
    if (got !== want) begin nFails++; $display("[TB] FAIL mid_reset_refetch: got %h expected %h", got, want); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    stim_t seq[$]; exp_t got, want;
    doReset(); busB.opcode = OP_R;
    for (int i = 0; i < 4; i++) seq.push_back(mkStim(0, 0, 0, eFetch(1'b0, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(HALT, 2'd2)));
    seq.push_back(mkStim(1, 0, 1, eZero(HALT, 2'd2)));
    foreach (seq[k]) begin
      applyStimulus(1, seq[k]);
      got = observe(1); want = expQ.pop_front(); nChecks++;
      if (got !== want) begin nFails++; $display("[TB] FAIL timeout[%0d]: got %h expected %h", k, got, want); end
      @(posedge clk); #1;
    end
    seq.delete();
    doReset();
    seq.push_back(mkStim(0, 0, 0, eFetch(1'b0, 2'd0)));
    seq.push_back(mkStim(0, 0, 0, eFetch(1'b0, 2'd0)));
    seq.push_back(mkStim(0, 1, 0, eZero(FETCH, 2'd0)));
    seq.push_back(mkStim(0, 1, 0, eZero(FETCH, 2'd0)));
    seq.push_back(mkStim(0, 0, 0, eFetch(1'b0, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    foreach (seq[k]) begin
      applyStimulus(1, seq[k]);
      got = observe(1); want = expQ.pop_front(); nChecks++;
      if (got !== want) begin nFails++; $display("[TB] FAIL ready_wins[%0d]: got %h expected %h", k, got, want); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_jal_disabled();
    stim_t seq[$]; exp_t got, want;
    doReset(); busB.opcode = OP_JAL;
    seq.push_back(mkStim(1, 0, 0, eFetch(1'b1, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(DECODE, 2'd0)));
    seq.push_back(mkStim(1, 0, 0, eZero(HALT, 2'd1)));
    foreach (seq[k]) begin
      applyStimulus(1, seq[k]);
      got = observe(1); want = expQ.pop_front(); nChecks++;
      if (got !== want) begin nFails++; $display("[TB] FAIL jal_disabled[%0d]: got %h expected %h", k, got, want); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    busA.opcode = 7'd0; busA.mem_ready = 1'b0; busA.ctrl_src = 1'b0; busA.flush = 1'b0;
    busB.opcode = 7'd0; busB.mem_ready = 1'b0; busB.ctrl_src = 1'b0; busB.flush = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_itype_flush();
    test_load_stall();
    test_store_freeze();
    test_branch_jal();
    test_illegal();
    test_mid_reset();
    test_timeout();
    test_jal_disabled();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters SHALL be, one per line:
  WAIT_MAX, 15, max cycles waiting for mem_ready before timeout error (1..255)
  EN_JAL, 1, 1 = decode JAL (1101111); 0 = treat as illegal
  ALUOP_W, 2, width of alu_op
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock, rising edge
  rst  in  1  reset, asynchronous, active-high
  opcode  in  7  instruction[6:0] from instruction register
  mem_ready  in  1  memory completes current read/write this cycle
  ctrl_src  in  1  bubble/freeze: force all write enables 0, hold state
  flush  in  1  abort current instruction, return to FETCH
  pc_write  out  1  PC update enable
  ir_write  out  1  instruction register load
  mem_read  out  1  memory read request
  mem_write  out  1  memory write request
  reg_write  out  1  register file write enable
  mem_to_reg  out  2  WB select: 0 ALU, 1 memory, 2 PC+4
  alu_src  out  1  0 = rs2, 1 = immediate
  alu_op  out  ALUOP_W  00 add, 01 branch compare, 10 R-type funct, 11 I-type funct
  branch  out  1  branch-compare cycle
  err  out  2  sticky error: 00 none, 01 illegal opcode, 10 memory timeout
  state  out  4  current state encoding (debug)

Function
REQ-003 FSM states SHALL be FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, HALT.
REQ-004 FETCH: mem_read=1; on mem_ready, ir_write=1 and pc_write=1 that cycle, next DECODE; else remain.
REQ-005 DECODE (one cycle) SHALL branch on opcode: 0110011->EXEC_R, 0010011->EXEC_I, 0000011/0100011->ADDR, 1100011->BRANCH, 1101111->JUMP if EN_JAL, all others->HALT with err=01.
REQ-006 EXEC_R: alu_src=0, alu_op=10 -> WB_ALU; EXEC_I: alu_src=1, alu_op=11 -> WB_ALU.
REQ-007 WB_ALU: reg_write=1, mem_to_reg=0 -> FETCH.
REQ-008 ADDR: alu_src=1, alu_op=00; next MEM_RD if opcode=0000011 else MEM_WR.
REQ-009 MEM_RD: mem_read=1, wait for mem_ready -> WB_MEM; WB_MEM: reg_write=1, mem_to_reg=1 -> FETCH.
REQ-010 MEM_WR: mem_write=1, wait for mem_ready -> FETCH.
REQ-011 BRANCH: branch=1, alu_src=0, alu_op=01, one cycle -> FETCH.
REQ-012 JUMP: pc_write=1, reg_write=1, mem_to_reg=2, one cycle -> FETCH.
REQ-013 Wait counter SHALL clear on entry to FETCH/MEM_RD/MEM_WR, increment each cycle mem_ready=0 there; reaching WAIT_MAX without mem_ready -> HALT, err=10.
REQ-014 mem_ready on the same cycle the counter reaches WAIT_MAX SHALL win (normal completion, no error).
REQ-015 HALT: all enables 0; remains until reset; flush SHALL NOT exit HALT; err holds.
REQ-016 Priority SHALL be rst > flush > ctrl_src > normal.
REQ-017 flush (not in HALT): all write enables and mem requests 0 that cycle; next state FETCH; counter cleared.
REQ-018 ctrl_src=1: pc_write, ir_write, reg_write, mem_write, mem_read forced 0; state and counter hold; other outputs follow state.
REQ-019 Outputs SHALL be combinational from state (plus mem_ready/ctrl_src/flush gating); state and counter registered; zero added latency.
REQ-020 Instruction latency (mem_ready always 1): R/I 4, load 5, store 4, branch 3, JAL 3 cycles.

Reset
REQ-021 rst=1 SHALL asynchronously set state=FETCH, counter=0, err=00; while rst=1 all outputs 0 except state=FETCH encoding.
REQ-022 First request (mem_read=1) SHALL appear in the first cycle after rst deasserts; reset mid-instruction discards it with no writes.

Structure
REQ-023 Package multicycle_control_pkg SHALL hold state enum, opcode constants, alu_op and mem_to_reg encodings, err codes.
REQ-024 Sub-module opcode_class (combinational opcode -> next-state class, EN_JAL parameter) SHALL be instantiated once.

Verification
REQ-025 add (0110011), mem_ready=1 -> FETCH,DECODE,EXEC_R,WB_ALU; reg_write=1 only in cycle 4, mem_to_reg=0.
REQ-026 lw (0000011), mem_ready low 3 cycles in MEM_RD -> mem_read held 4 cycles, WB_MEM reg_write=1, mem_to_reg=1, err=00.
REQ-027 opcode 1111111 -> HALT after DECODE, err=01, all enables 0; flush ignored; rst returns FETCH, err=00.
REQ-028 WAIT_MAX=4, mem_ready=0 in FETCH -> HALT after 4 wait cycles, err=10; repeat with mem_ready on 4th cycle -> DECODE, err=00.
REQ-029 sw with ctrl_src=1 for 2 cycles in MEM_WR -> mem_write=0, state held; released -> mem_write=1, completes on mem_ready.
REQ-030 flush during EXEC_I -> no reg_write, next FETCH; EN_JAL=0 with 1101111 -> err=01.
